idm_port_arbiter: RTL and testbench
===================================

Name: idm_port_arbiter

Overview:
- Shares the single-port instruction/data memory between the multi-cycle processor's fetch unit and its load/store unit.
- Accepts one request at a time through a req/ack handshake and drives the memory's address, write-enable and write-data pins.
- Captures the 16-bit read word into a register and returns it to the winning requester with a one-cycle ack.
- Sits between the control unit and the memory; it is the only master of the memory port.

Parameters:
- ADDR_W, 8: byte address width; the memory word index is addr[ADDR_W-1:1].
- DATA_W, 16: memory read word width.
- WDATA_W, 8: write data width; the memory zero-extends writes to DATA_W.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held until f_ack
- f_addr  in  ADDR_W  fetch byte address
- f_ack  out  1  one-cycle pulse; f_rdata valid in the same cycle
- f_rdata  out  DATA_W  fetched word
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  WDATA_W  store data
- d_ack  out  1  one-cycle pulse; d_rdata valid in the same cycle for loads
- d_rdata  out  DATA_W  loaded word
- mem_addr  out  ADDR_W  to memory address
- mem_write_enable  out  1  to memory write enable
- mem_write_data  out  WDATA_W  to memory write data
- mem_read_data  in  DATA_W  from memory; combinational read of mem_addr
- busy  out  1  high in ACCESS and DONE states

Behaviour:
- Reset values: all outputs 0; state IDLE; holding registers 0; last_grant = DATA.
  - Reset takes priority over every other event, including in ACCESS.
  - Reset during ACCESS forces mem_write_enable low that cycle, so no write is issued.
  - Reset during DONE suppresses the ack.
- FSM has three states.
  - IDLE:
    - If any req is high, select a winner and latch its addr, we (0 for fetch) and wdata into holding registers; go to ACCESS.
    - Otherwise stay in IDLE.
  - ACCESS (one cycle):
    - mem_addr = held addr.
    - mem_write_enable = held we; mem_write_data = held wdata.
    - At the rising edge, capture mem_read_data into the winner's rdata register; go to DONE.
  - DONE (one cycle):
    - Winner's ack = 1; rdata holds its value.
    - Go to IDLE.
    - The requester drops req at this edge; the arbiter does not sample requests in DONE.
- Latency: req sampled at edge N → ACCESS in cycle N+1 → ack in cycle N+2. Throughput is one access per 3 cycles.
- mem_addr, mem_write_enable and mem_write_data are 0 outside ACCESS.
- A store's d_rdata holds the pre-write word (value read during the write cycle).
- rdata registers hold their last value until the next access by the same requester.
- Priority: fixed, data over fetch. When both requests are high in IDLE, data wins and fetch waits; the fetch is served in the next IDLE.
- Addresses pass through unchanged. addr[0] is ignored by the memory, so odd and even bytes of a word alias.
- A req dropped before ack is a protocol violation. Once latched, the access completes regardless.
- last_grant updates at every IDLE→ACCESS transition.

Optional Feature:
- Macro: IDM_ARB_ROUND_ROBIN_EN.
- Defined: when both requests are high in IDLE, grant goes to the requester that is not last_grant. After reset (last_grant = DATA), a simultaneous request is granted to fetch first.
- Not defined: fixed data-over-fetch priority; last_grant is still maintained but unused.
- Single-requester behaviour is identical in both builds.

Test Plan:
- Reset with memory preloaded, then f_req, f_addr=0x02 → f_ack in the 2nd cycle after sampling, f_rdata=0x8907; d_ack stays 0.
- d_req, d_we=1, d_addr=0x20, d_wdata=0xA5, then load from 0x20 → memory word 16 = 0x00A5; mem_write_enable high for exactly one cycle; load d_rdata=0x00A5.
- f_req (addr 0x00) and d_req (load, addr 0x02) both raised in the same cycle, default build → d_ack first with 0x8907, then f_ack 3 cycles later with 0x8802. With IDM_ARB_ROUND_ROBIN_EN defined, fetch is served first.
- Store in flight with reset asserted in the ACCESS cycle → mem_write_enable=0, no ack, busy=0 next cycle, target word unchanged.
- Load from odd address 0x03 → d_rdata=0x8907, identical to address 0x02.
- Fetch requests held continuously back-to-back for 4 accesses → exactly one f_ack per 3 cycles; busy deasserts only in IDLE cycles.

Source files
------------

// File: rtl/idm_port_arbiter.sv
// ---------------------------------------------------------------------------
// idm_port_arbiter
//
// Shares the single-port instruction/data memory between the fetch unit and
// the load/store unit. One access is in flight at a time and takes three
// cycles: IDLE (request sampled), ACCESS (memory pins driven, read word
// captured on the closing edge), DONE (one-cycle ack to the winner).
//
// Optional build macro:
//   IDM_ARB_ROUND_ROBIN_EN - on a simultaneous request the requester that did
//                            not win last time is granted. Without it data
//                            always beats fetch.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   f_req/f_addr          fetch request (held until f_ack) and byte address
//   f_ack/f_rdata         one-cycle ack pulse, fetched word
//   d_req/d_we/d_addr/    data request (held until d_ack), 1 = store,
//   d_wdata               byte address, store data
//   d_ack/d_rdata         one-cycle ack pulse, loaded (or pre-store) word
//   mem_addr/             memory address, write enable and write data;
//   mem_write_enable/     all zero outside the ACCESS cycle
//   mem_write_data
//   mem_read_data         combinational read of mem_addr
//   busy                  high while an access is in ACCESS or DONE
// ---------------------------------------------------------------------------
module idm_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int WDATA_W = 8
) (
    input  logic               clock,
    input  logic               reset,

    input  logic               f_req,
    input  logic [ADDR_W-1:0]  f_addr,
    output logic               f_ack,
    output logic [DATA_W-1:0]  f_rdata,

    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [WDATA_W-1:0] d_wdata,
    output logic               d_ack,
    output logic [DATA_W-1:0]  d_rdata,

    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_write_enable,
    output logic [WDATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0]  mem_read_data,

    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Holding registers for the access in flight.
    logic [ADDR_W-1:0]  held_addr;
    logic               held_we;
    logic [WDATA_W-1:0] held_wdata;
    logic               held_data;        // 1 = data port won, 0 = fetch

    // Winner of the most recent IDLE->ACCESS transition (1 = data).
    logic               last_grant_data;

    logic [DATA_W-1:0]  f_rdata_q;
    logic [DATA_W-1:0]  d_rdata_q;

    logic               any_req;
    logic               grant_data;

    assign any_req = f_req | d_req;

`ifdef IDM_ARB_ROUND_ROBIN_EN
    // Contended: hand the port to whoever did not win last time.
    assign grant_data = d_req & (~f_req | ~last_grant_data);
`else
    // Fixed priority: data always beats fetch.
    assign grant_data = d_req;

    // last_grant is still tracked in this build but nothing consumes it.
    logic unused_last_grant;
    assign unused_last_grant = last_grant_data;
`endif

    // -----------------------------------------------------------------------
    // State register and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            held_addr       <= '0;
            held_we         <= 1'b0;
            held_wdata      <= '0;
            held_data       <= 1'b0;
            last_grant_data <= 1'b1;
            f_rdata_q       <= '0;
            d_rdata_q       <= '0;
        end else begin
            state <= state_nxt;

            if (state == S_IDLE && any_req) begin
                held_data       <= grant_data;
                last_grant_data <= grant_data;
                if (grant_data) begin
                    held_addr  <= d_addr;
                    held_we    <= d_we;
                    held_wdata <= d_wdata;
                end else begin
                    held_addr  <= f_addr;
                    held_we    <= 1'b0;
                    held_wdata <= '0;
                end
            end

            // A store also captures: the requester sees the pre-write word.
            if (state == S_ACCESS) begin
                if (held_data)
                    d_rdata_q <= mem_read_data;
                else
                    f_rdata_q <= mem_read_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next state and outputs. Outputs are gated by reset so that a reset in
    // ACCESS never issues a write and a reset in DONE never acks.
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt        = state;
        mem_addr         = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        f_ack            = 1'b0;
        d_ack            = 1'b0;
        busy             = 1'b0;

        case (state)
            S_IDLE: begin
                if (any_req)
                    state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                state_nxt = S_DONE;
                if (!reset) begin
                    mem_addr         = held_addr;
                    mem_write_enable = held_we;
                    mem_write_data   = held_wdata;
                    busy             = 1'b1;
                end
            end
            S_DONE: begin
                // Requests are deliberately not sampled here; the winner is
                // dropping its req on this edge.
                state_nxt = S_IDLE;
                if (!reset) begin
                    busy  = 1'b1;
                    d_ack = held_data;
                    f_ack = ~held_data;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign f_rdata = f_rdata_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_idm_port_arbiter.sv
module tb_idm_port_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int WDATA_W = 8;

    logic               clock;
    logic               reset;
    logic               f_req;
    logic [ADDR_W-1:0]  f_addr;
    logic               f_ack;
    logic [DATA_W-1:0]  f_rdata;
    logic               d_req;
    logic               d_we;
    logic [ADDR_W-1:0]  d_addr;
    logic [WDATA_W-1:0] d_wdata;
    logic               d_ack;
    logic [DATA_W-1:0]  d_rdata;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_write_enable;
    logic [WDATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0]  mem_read_data;
    logic               busy;

    int vectors;
    int errors;

    idm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WDATA_W(WDATA_W)) dut (
        .clock(clock), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory environment: combinational read, write zero-extended on the edge.
    logic [DATA_W-1:0] mem     [0:127];
    logic [DATA_W-1:0] ref_mem [0:127];
    logic              ref_lg_data;   // model of last grant, 1 = data

    assign mem_read_data = mem[mem_addr[ADDR_W-1:1]];
    always @(posedge clock)
        if (mem_write_enable) mem[mem_addr[ADDR_W-1:1]] <= {8'h00, mem_write_data};

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic init_mem;
        for (int i = 0; i < 128; i++) begin
            logic [DATA_W-1:0] w;
            if (i == 0)      w = 16'h8802;
            else if (i == 1) w = 16'h8907;
            else             w = 16'(i * 16'h0301) ^ 16'h5A3C;
            mem[i]     = w;
            ref_mem[i] = w;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        step; step;
        reset = 1'b0;
        ref_lg_data = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        step; step;
        vectors++;
        if ({f_ack, d_ack, busy, mem_write_enable, f_rdata, d_rdata, mem_addr, mem_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_held: outputs got %h, need 0",
                     {f_ack, d_ack, busy, mem_write_enable, f_rdata, d_rdata, mem_addr, mem_write_data});
        end
        reset = 1'b0;
        ref_lg_data = 1'b1;
        step;
        vectors++;
        if ({f_ack, d_ack, busy, mem_write_enable, f_rdata, d_rdata, mem_addr, mem_write_data} !== '0) begin
            errors++;
            $display("FAIL reset_idle: outputs got %h, need 0",
                     {f_ack, d_ack, busy, mem_write_enable, f_rdata, d_rdata, mem_addr, mem_write_data});
        end
    endtask

    task automatic test_fetch;
        f_addr = 8'h02;
        f_req  = 1'b1;
        step;   // ACCESS
        vectors++;
        if ({f_ack, d_ack, busy, mem_addr} !== {1'b0, 1'b0, 1'b1, 8'h02}) begin
            errors++;
            $display("FAIL fetch_access: ack/busy/addr got %b %b %b %h, need 0 0 1 02", f_ack, d_ack, busy, mem_addr);
        end
        step;   // DONE
        vectors++;
        if ({f_ack, d_ack, f_rdata} !== {1'b1, 1'b0, 16'h8907}) begin
            errors++;
            $display("FAIL fetch_done: f_ack %b d_ack %b f_rdata %h, need 1 0 8907", f_ack, d_ack, f_rdata);
        end
        f_req = 1'b0;
        step;   // IDLE
        vectors++;
        if ({f_ack, busy, f_rdata} !== {1'b0, 1'b0, 16'h8907}) begin
            errors++;
            $display("FAIL fetch_idle: f_ack %b busy %b f_rdata %h, need 0 0 8907", f_ack, busy, f_rdata);
        end
        ref_lg_data = 1'b0;
    endtask

    task automatic test_store_load;
        int we_cnt;
        we_cnt = 0;
        d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'hA5; d_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step;
            if (mem_write_enable) we_cnt++;
            if (k == 2) begin
                vectors++;
                if (d_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL store_ack: d_ack %b, need 1", d_ack);
                end
                d_req = 1'b0;
            end
        end
        d_we = 1'b0; d_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step;
            if (mem_write_enable) we_cnt++;
            if (k == 2) begin
                vectors++;
                if ({d_ack, d_rdata} !== {1'b1, 16'h00A5}) begin
                    errors++;
                    $display("FAIL load_after_store: d_ack %b d_rdata %h, need 1 00a5", d_ack, d_rdata);
                end
                d_req = 1'b0;
            end
        end
        vectors++;
        if (we_cnt !== 1 || mem[16] !== 16'h00A5) begin
            errors++;
            $display("FAIL store_write: we cycles %0d word16 %h, need 1 00a5", we_cnt, mem[16]);
        end
        ref_mem[16] = 16'h00A5;
        ref_lg_data = 1'b1;
    endtask

    task automatic test_priority;
        int f_cyc, d_cyc, f_cnt, d_cnt;
        logic [DATA_W-1:0] f_val, d_val;
        int exp_f, exp_d;
        do_reset;
        f_cyc = 0; d_cyc = 0; f_cnt = 0; d_cnt = 0; f_val = '0; d_val = '0;
        f_addr = 8'h00; d_addr = 8'h02; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step;
            if (f_ack) begin f_cnt++; f_cyc = k; f_val = f_rdata; f_req = 1'b0; end
            if (d_ack) begin d_cnt++; d_cyc = k; d_val = d_rdata; d_req = 1'b0; end
        end
`ifdef IDM_ARB_ROUND_ROBIN_EN
        exp_f = 2; exp_d = 5; ref_lg_data = 1'b1;
`else
        exp_f = 5; exp_d = 2; ref_lg_data = 1'b0;
`endif
        vectors++;
        if (d_cnt !== 1 || d_cyc !== exp_d || d_val !== 16'h8907) begin
            errors++;
            $display("FAIL prio_data: acks %0d at %0d val %h, need 1 at %0d 8907", d_cnt, d_cyc, d_val, exp_d);
        end
        vectors++;
        if (f_cnt !== 1 || f_cyc !== exp_f || f_val !== 16'h8802) begin
            errors++;
            $display("FAIL prio_fetch: acks %0d at %0d val %h, need 1 at %0d 8802", f_cnt, f_cyc, f_val, exp_f);
        end
    endtask

    task automatic test_reset_in_access;
        d_we = 1'b1; d_addr = 8'h30; d_wdata = 8'h5A; d_req = 1'b1;
        step;   // ACCESS
        reset = 1'b1;
        #1;
        vectors++;
        if ({mem_write_enable, mem_addr} !== 9'h0) begin
            errors++;
            $display("FAIL rst_access_we: we %b addr %h, need 0 00", mem_write_enable, mem_addr);
        end
        step;
        reset = 1'b0; d_req = 1'b0; d_we = 1'b0;
        ref_lg_data = 1'b1;
        #1;
        vectors++;
        if ({busy, d_ack, d_rdata} !== 18'h0 || mem[24] !== ref_mem[24]) begin
            errors++;
            $display("FAIL rst_access_after: busy %b d_ack %b d_rdata %h word24 %h, need 0 0 0000 %h",
                     busy, d_ack, d_rdata, mem[24], ref_mem[24]);
        end
        step;
        vectors++;
        if ({busy, d_ack} !== 2'b00) begin
            errors++;
            $display("FAIL rst_access_noack: busy %b d_ack %b, need 0 0", busy, d_ack);
        end
    endtask

    task automatic test_odd_addr;
        logic [ADDR_W-1:0] addrs [2];
        addrs[0] = 8'h03; addrs[1] = 8'h02;
        for (int a = 0; a < 2; a++) begin
            d_we = 1'b0; d_addr = addrs[a]; d_req = 1'b1;
            step; step;
            vectors++;
            if ({d_ack, d_rdata} !== {1'b1, 16'h8907}) begin
                errors++;
                $display("FAIL odd_addr_%h: d_ack %b d_rdata %h, need 1 8907", addrs[a], d_ack, d_rdata);
            end
            d_req = 1'b0;
            step;
        end
        ref_lg_data = 1'b1;
    endtask

    task automatic test_back_to_back;
        int acks;
        acks = 0;
        f_addr = 8'h04; f_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step;
            vectors++;
            if (f_ack !== (k % 3 == 2) || busy !== (k % 3 != 0)) begin
                errors++;
                $display("FAIL b2b_cycle%0d: f_ack %b busy %b, need %b %b", k, f_ack, busy, (k % 3 == 2), (k % 3 != 0));
            end
            if (f_ack) begin
                acks++;
                vectors++;
                if (f_rdata !== ref_mem[2]) begin
                    errors++;
                    $display("FAIL b2b_data%0d: f_rdata %h, need %h", k, f_rdata, ref_mem[2]);
                end
            end
            if (k == 11) f_req = 1'b0;
        end
        vectors++;
        if (acks !== 4) begin
            errors++;
            $display("FAIL b2b_count: %0d acks, need 4", acks);
        end
        ref_lg_data = 1'b0;
    endtask

    // Randomised transactions against a transaction-level model: order
    // from the grant rule, read data from a model memory, one access every
    // three cycles starting with ACCESS in the first cycle after sampling.
    task automatic test_random;
        for (int it = 0; it < 40; it++) begin
            logic [1:0]         r;
            logic               f_en, d_en, dwe, data_first;
            logic [ADDR_W-1:0]  fa, da;
            logic [WDATA_W-1:0] wd;
            int                 n;
            logic               e_data [2];
            logic [ADDR_W-1:0]  e_addr [2];
            logic               e_we   [2];
            logic [WDATA_W-1:0] e_wd   [2];
            logic [DATA_W-1:0]  e_rd   [2];

            r    = 2'($urandom_range(1, 3));
            f_en = r[0]; d_en = r[1];
            fa   = 8'($urandom); da = 8'($urandom); wd = 8'($urandom);
            dwe  = 1'($urandom);
`ifdef IDM_ARB_ROUND_ROBIN_EN
            data_first = d_en & (~f_en | ~ref_lg_data);
`else
            data_first = d_en;
`endif
            n = 0;
            for (int s = 0; s < 2; s++) begin
                logic pick_data, en;
                pick_data = (s == 0) ? data_first : ~data_first;
                en = pick_data ? d_en : f_en;
                if (en) begin
                    e_data[n] = pick_data;
                    e_addr[n] = pick_data ? da : fa;
                    e_we[n]   = pick_data & dwe;
                    e_wd[n]   = pick_data ? wd : 8'h00;
                    e_rd[n]   = ref_mem[e_addr[n][ADDR_W-1:1]];
                    if (e_we[n]) ref_mem[e_addr[n][ADDR_W-1:1]] = {8'h00, wd};
                    ref_lg_data = pick_data;
                    n++;
                end
            end

            f_addr = fa; d_addr = da; d_we = dwe; d_wdata = wd;
            f_req = f_en; d_req = d_en;
            for (int k = 1; k <= 3 * n; k++) begin
                int slot, ph;
                slot = (k - 1) / 3;
                ph   = (k - 1) % 3;
                step;
                vectors++;
                if (ph == 0) begin
                    if ({busy, f_ack, d_ack, mem_write_enable, mem_addr, mem_write_data} !==
                        {1'b1, 1'b0, 1'b0, e_we[slot], e_addr[slot], e_wd[slot]}) begin
                        errors++;
                        $display("FAIL rand%0d_access%0d: busy/acks/we/addr/wd %b%b%b %b %h %h, need 100 %b %h %h",
                                 it, slot, busy, f_ack, d_ack, mem_write_enable, mem_addr, mem_write_data,
                                 e_we[slot], e_addr[slot], e_wd[slot]);
                    end
                end else if (ph == 1) begin
                    if ({busy, f_ack, d_ack, mem_write_enable, mem_addr} !==
                        {1'b1, ~e_data[slot], e_data[slot], 1'b0, 8'h00}) begin
                        errors++;
                        $display("FAIL rand%0d_done%0d: busy %b f_ack %b d_ack %b we %b addr %h, need 1 %b %b 0 00",
                                 it, slot, busy, f_ack, d_ack, mem_write_enable, mem_addr,
                                 ~e_data[slot], e_data[slot]);
                    end
                    vectors++;
                    if ((e_data[slot] ? d_rdata : f_rdata) !== e_rd[slot]) begin
                        errors++;
                        $display("FAIL rand%0d_rdata%0d: got %h, need %h", it, slot,
                                 (e_data[slot] ? d_rdata : f_rdata), e_rd[slot]);
                    end
                    if (e_data[slot]) d_req = 1'b0; else f_req = 1'b0;
                end else begin
                    if ({busy, f_ack, d_ack, mem_write_enable, mem_addr, mem_write_data} !== 20'h0) begin
                        errors++;
                        $display("FAIL rand%0d_idle%0d: busy %b acks %b%b we %b addr %h wd %h, need all 0",
                                 it, slot, busy, f_ack, d_ack, mem_write_enable, mem_addr, mem_write_data);
                    end
                end
            end
        end

        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 128; i++)
                if (mem[i] !== ref_mem[i]) bad++;
            vectors++;
            if (bad !== 0) begin
                errors++;
                $display("FAIL rand_memory: %0d words differ, need 0", bad);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset = 1'b1;
        f_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        init_mem;
        test_reset;
        test_fetch;
        test_store_load;
        test_priority;
        test_reset_in_access;
        test_odd_addr;
        test_back_to_back;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
